// File: rtl/keypad_seq_ctrl.sv
// keypad_seq_ctrl
// Keypad sequencing FSM between the keypad scanner and the calculator
// operand registers / ALU. Turns 5-bit key codes into digit writes,
// operand A/B toggles and ALU op requests. It waits for a settled key
// release before accepting the next key, caps the digits per operand and
// gives up on an ALU op that never reports completion.
module keypad_seq_ctrl #(
    parameter int RELEASE_CYCLES = 10000,
    parameter int NDIGITS        = 4,
    parameter int EXEC_TIMEOUT   = 65535
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [4:0]                       key,
    input  logic                             op_done,
    output logic [1:0]                       st,
    output logic [$clog2(NDIGITS+1)-1:0]     index,
    output logic                             operand_b,
    output logic [2:0]                       op_sel,
    output logic                             digit_we,
    output logic [3:0]                       digit_val,
    output logic [$clog2(NDIGITS+1)-1:0]     digit_pos,
    output logic                             op_start,
    output logic                             err_ovf,
    output logic                             err_timeout
);

    localparam int IW       = $clog2(NDIGITS + 1);
    localparam int CNT_MAX  = (RELEASE_CYCLES > EXEC_TIMEOUT) ? RELEASE_CYCLES : EXEC_TIMEOUT;
    localparam int CW       = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_CYCLES - 1);
    localparam logic [CW-1:0] EXEC_LAST = CW'(EXEC_TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_FULL  = IW'(NDIGITS);

    localparam logic [4:0] KEY_A    = 5'd10;
    localparam logic [4:0] KEY_F    = 5'd15;
    localparam logic [4:0] KEY_NONE = 5'd16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIG_HOLD = 2'd1,
        OP_HOLD  = 2'd2,
        EXEC     = 2'd3
    } state_t;

    state_t          st_q, st_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [IW-1:0]   index_n;
    logic            operand_b_n;
    logic [2:0]      op_sel_n;
    logic            digit_we_n;
    logic [3:0]      digit_val_n;
    logic [IW-1:0]   digit_pos_n;
    logic            op_start_n;
    logic            err_ovf_n;
    logic            err_timeout_n;
    logic [4:0]      op_code;

    assign st = st_q;

    // Register every output so downstream logic sees clean, glitch-free strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            index       <= '0;
            operand_b   <= 1'b0;
            op_sel      <= 3'd0;
            digit_we    <= 1'b0;
            digit_val   <= 4'd0;
            digit_pos   <= '0;
            op_start    <= 1'b0;
            err_ovf     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            st_q        <= st_n;
            cnt_q       <= cnt_n;
            index       <= index_n;
            operand_b   <= operand_b_n;
            op_sel      <= op_sel_n;
            digit_we    <= digit_we_n;
            digit_val   <= digit_val_n;
            digit_pos   <= digit_pos_n;
            op_start    <= op_start_n;
            err_ovf     <= err_ovf_n;
            err_timeout <= err_timeout_n;
        end
    end

    // Next-state and next-output decode; pulses default low so each lasts one cycle.
    always_comb begin
        st_n          = st_q;
        cnt_n         = cnt_q;
        index_n       = index;
        operand_b_n   = operand_b;
        op_sel_n      = op_sel;
        digit_we_n    = 1'b0;
        digit_val_n   = digit_val;
        digit_pos_n   = digit_pos;
        op_start_n    = 1'b0;
        err_ovf_n     = 1'b0;
        err_timeout_n = 1'b0;
        op_code       = key - KEY_A;

        case (st_q)
            IDLE: begin
                cnt_n = '0;
                if (key < KEY_A) begin
                    st_n = DIG_HOLD;
                    if (index < IDX_FULL) begin
                        digit_we_n  = 1'b1;
                        digit_val_n = key[3:0];
                        digit_pos_n = index;
                        index_n     = index + 1'b1;
                    end else begin
                        err_ovf_n = 1'b1;
                    end
                end else if (key == KEY_A) begin
                    st_n        = DIG_HOLD;
                    operand_b_n = ~operand_b;
                    index_n     = '0;
                end else if (key <= KEY_F) begin
                    st_n     = OP_HOLD;
                    op_sel_n = op_code[2:0];
                    index_n  = '0;
                end
            end

            DIG_HOLD, OP_HOLD: begin
                if (key == KEY_NONE) begin
                    if (cnt_q == REL_LAST) begin
                        cnt_n = '0;
                        if (st_q == DIG_HOLD) begin
                            st_n = IDLE;
                        end else begin
                            st_n       = EXEC;
                            op_start_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_n = '0;
                end
            end

            EXEC: begin
                if (op_done) begin
                    st_n     = IDLE;
                    cnt_n    = '0;
                    op_sel_n = 3'd0;
                end else if (cnt_q == EXEC_LAST) begin
                    st_n          = IDLE;
                    cnt_n         = '0;
                    op_sel_n      = 3'd0;
                    err_timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end

            default: begin
                st_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_seq_ctrl.sv
// tb_keypad_seq_ctrl
// Directed bench for keypad_seq_ctrl with RELEASE_CYCLES=4, NDIGITS=2,
// EXEC_TIMEOUT=8. Inputs change #1 after the rising edge, outputs are
// checked at the same point.
module tb_keypad_seq_ctrl;

    localparam logic [4:0] NONE = 5'd16;

    logic       clk;
    logic       rst;
    logic [4:0] key;
    logic       op_done;
    logic [1:0] st;
    logic [1:0] index;
    logic       operand_b;
    logic [2:0] op_sel;
    logic       digit_we;
    logic [3:0] digit_val;
    logic [1:0] digit_pos;
    logic       op_start;
    logic       err_ovf;
    logic       err_timeout;

    int errors = 0;
    int checks = 0;

    keypad_seq_ctrl #(
        .RELEASE_CYCLES(4),
        .NDIGITS(2),
        .EXEC_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .op_done(op_done),
        .st(st),
        .index(index),
        .operand_b(operand_b),
        .op_sel(op_sel),
        .digit_we(digit_we),
        .digit_val(digit_val),
        .digit_pos(digit_pos),
        .op_start(op_start),
        .err_ovf(err_ovf),
        .err_timeout(err_timeout)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] k, input logic d);
        key     = k;
        op_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(NONE, 1'b0);
        applyStimulus(NONE, 1'b0);
        rst = 1'b0;
    endtask

    // Drive NONE for n-1 cycles expecting the hold state, then one more expecting nextSt.
    task automatic releaseKey(input string tag, input logic [1:0] holdSt, input logic [1:0] nextSt);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(NONE, 1'b0);
            checkOutput({tag, "_hold_st"}, 32'(st), 32'(holdSt));
        end
        applyStimulus(NONE, 1'b0);
        checkOutput({tag, "_exit_st"}, 32'(st), 32'(nextSt));
    endtask

    initial begin
        rst     = 1'b1;
        key     = NONE;
        op_done = 1'b0;
        #1;
        doReset();
        checkOutput("rst_st", 32'(st), 0);
        checkOutput("rst_index", 32'(index), 0);
        checkOutput("rst_operand_b", 32'(operand_b), 0);
        checkOutput("rst_op_sel", 32'(op_sel), 0);
        checkOutput("rst_digit_we", 32'(digit_we), 0);
        checkOutput("rst_digit_val", 32'(digit_val), 0);
        checkOutput("rst_digit_pos", 32'(digit_pos), 0);
        checkOutput("rst_pulses", {29'd0, op_start, err_ovf, err_timeout}, 0);

        // Single digit 5, then four NONE cycles to return to IDLE.
        applyStimulus(5'd5, 1'b0);
        checkOutput("d5_st", 32'(st), 1);
        checkOutput("d5_we", 32'(digit_we), 1);
        checkOutput("d5_val", 32'(digit_val), 5);
        checkOutput("d5_pos", 32'(digit_pos), 0);
        checkOutput("d5_index", 32'(index), 1);
        applyStimulus(NONE, 1'b0);
        checkOutput("d5_we_pulse", 32'(digit_we), 0);
        checkOutput("d5_st_n1", 32'(st), 1);
        applyStimulus(NONE, 1'b0);
        checkOutput("d5_st_n2", 32'(st), 1);
        applyStimulus(NONE, 1'b0);
        checkOutput("d5_st_n3", 32'(st), 1);
        applyStimulus(NONE, 1'b0);
        checkOutput("d5_st_n4", 32'(st), 0);

        // op_done and invalid codes are ignored in IDLE.
        applyStimulus(5'd20, 1'b1);
        checkOutput("idle_ign_st", 32'(st), 0);
        checkOutput("idle_ign_index", 32'(index), 1);

        // Digits 1,2,3 from a clean operand: the third overflows.
        doReset();
        applyStimulus(5'd1, 1'b0);
        checkOutput("d1_we", 32'(digit_we), 1);
        checkOutput("d1_val", 32'(digit_val), 1);
        checkOutput("d1_pos", 32'(digit_pos), 0);
        releaseKey("d1", 2'd1, 2'd0);
        applyStimulus(5'd2, 1'b0);
        checkOutput("d2_we", 32'(digit_we), 1);
        checkOutput("d2_val", 32'(digit_val), 2);
        checkOutput("d2_pos", 32'(digit_pos), 1);
        checkOutput("d2_index", 32'(index), 2);
        releaseKey("d2", 2'd1, 2'd0);
        applyStimulus(5'd3, 1'b0);
        checkOutput("d3_st", 32'(st), 1);
        checkOutput("d3_ovf", 32'(err_ovf), 1);
        checkOutput("d3_we", 32'(digit_we), 0);
        checkOutput("d3_index", 32'(index), 2);
        applyStimulus(NONE, 1'b0);
        checkOutput("d3_ovf_pulse", 32'(err_ovf), 0);
        applyStimulus(NONE, 1'b0);
        applyStimulus(NONE, 1'b0);
        applyStimulus(NONE, 1'b0);
        checkOutput("d3_exit_st", 32'(st), 0);

        // Bouncing key in DIG_HOLD restarts the release count without a second write.
        doReset();
        applyStimulus(5'd4, 1'b0);
        checkOutput("b4_we", 32'(digit_we), 1);
        applyStimulus(NONE, 1'b0);
        applyStimulus(NONE, 1'b0);
        applyStimulus(5'd7, 1'b0);
        checkOutput("b7_st", 32'(st), 1);
        checkOutput("b7_we", 32'(digit_we), 0);
        checkOutput("b7_index", 32'(index), 1);
        releaseKey("b7", 2'd1, 2'd0);
        checkOutput("b7_val_kept", 32'(digit_val), 4);

        // Op C, release, EXEC with op_done on the third EXEC cycle.
        applyStimulus(5'd12, 1'b0);
        checkOutput("opc_st", 32'(st), 2);
        checkOutput("opc_sel", 32'(op_sel), 2);
        checkOutput("opc_index", 32'(index), 0);
        releaseKey("opc", 2'd2, 2'd3);
        checkOutput("opc_start", 32'(op_start), 1);
        applyStimulus(5'd3, 1'b0);
        checkOutput("opc_start_pulse", 32'(op_start), 0);
        checkOutput("opc_key_ign_st", 32'(st), 3);
        applyStimulus(NONE, 1'b0);
        checkOutput("opc_exec3_st", 32'(st), 3);
        applyStimulus(NONE, 1'b1);
        checkOutput("opc_done_st", 32'(st), 0);
        checkOutput("opc_done_sel", 32'(op_sel), 0);
        checkOutput("opc_done_tmo", 32'(err_timeout), 0);
        checkOutput("opc_done_index", 32'(index), 0);

        // Op F with no op_done: abort after 8 EXEC cycles.
        applyStimulus(5'd15, 1'b0);
        checkOutput("opf_sel", 32'(op_sel), 5);
        releaseKey("opf", 2'd2, 2'd3);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(NONE, 1'b0);
            checkOutput("opf_exec_st", 32'(st), 3);
            checkOutput("opf_exec_tmo", 32'(err_timeout), 0);
        end
        applyStimulus(NONE, 1'b0);
        checkOutput("opf_tmo", 32'(err_timeout), 1);
        checkOutput("opf_tmo_st", 32'(st), 0);
        checkOutput("opf_tmo_sel", 32'(op_sel), 0);
        applyStimulus(NONE, 1'b0);
        checkOutput("opf_tmo_pulse", 32'(err_timeout), 0);

        // Op D with op_done arriving on the timeout cycle: done wins.
        applyStimulus(5'd13, 1'b0);
        checkOutput("opd_sel", 32'(op_sel), 3);
        releaseKey("opd", 2'd2, 2'd3);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(NONE, 1'b0);
        end
        checkOutput("opd_exec8_st", 32'(st), 3);
        applyStimulus(NONE, 1'b1);
        checkOutput("opd_done_st", 32'(st), 0);
        checkOutput("opd_done_tmo", 32'(err_timeout), 0);

        // Operand toggle twice.
        applyStimulus(5'd10, 1'b0);
        checkOutput("tga1_opb", 32'(operand_b), 1);
        checkOutput("tga1_st", 32'(st), 1);
        releaseKey("tga1", 2'd1, 2'd0);
        applyStimulus(5'd10, 1'b0);
        checkOutput("tga2_opb", 32'(operand_b), 0);
        releaseKey("tga2", 2'd1, 2'd0);

        // Reset while in EXEC clears everything on the next edge.
        applyStimulus(5'd10, 1'b0);
        releaseKey("tga3", 2'd1, 2'd0);
        applyStimulus(5'd11, 1'b0);
        checkOutput("opb_sel", 32'(op_sel), 1);
        releaseKey("opb", 2'd2, 2'd3);
        checkOutput("opb_start", 32'(op_start), 1);
        rst = 1'b1;
        applyStimulus(NONE, 1'b0);
        rst = 1'b0;
        checkOutput("mrst_st", 32'(st), 0);
        checkOutput("mrst_sel", 32'(op_sel), 0);
        checkOutput("mrst_opb", 32'(operand_b), 0);
        checkOutput("mrst_pulses", {29'd0, op_start, err_ovf, err_timeout}, 0);
        applyStimulus(NONE, 1'b0);
        checkOutput("mrst_idle_st", 32'(st), 0);
        checkOutput("mrst_idle_pulses", {29'd0, op_start, err_ovf, err_timeout}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
